// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding IF/ID, single outstanding imem request
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_inst_out,
    output logic        if_id_wen,
    output logic        if_id_flush,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
    logic        redirect_act;
    logic        deliver_wait;
    logic        deliver_hold;
    logic        deliver;

    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    // A redirect before the first request has nothing to squash, so IDLE ignores it.
    assign redirect_act = redirect_valid && (state_q != ST_IDLE);
    assign deliver_wait = (state_q == ST_WAIT) && imem_rvalid && !drop_q && !stall
                          && !redirect_act;
    assign deliver_hold = (state_q == ST_HOLD) && !stall && !redirect_act;
    assign deliver      = deliver_wait || deliver_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            inst_buf_q    <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            inst_buf_q    <= inst_buf_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        inst_buf_d    = inst_buf_q;
        fetch_count_d = fetch_count_q;

        if (deliver) begin
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (redirect_act) begin
            pc_d = redirect_tgt;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ready) begin
                    state_d = ST_WAIT;
                    // The accepted request carries the old address; its response must be dropped.
                    drop_d  = redirect_act;
                end
            end
            ST_WAIT: begin
                if (redirect_act) begin
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end else if (stall) begin
                        state_d    = ST_HOLD;
                        inst_buf_d = imem_rdata;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_act || !stall) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        if_inst_out = 32'd0;
        if_pc_out   = 32'd0;
        if_id_wen   = 1'b0;
        if_id_flush = 1'b0;
        if (!rst) begin
            imem_req = (state_q == ST_REQ);
            if (state_q == ST_HOLD) begin
                if_inst_out = inst_buf_q;
                if_pc_out   = pc_plus4;
            end else if (deliver_wait) begin
                if_inst_out = imem_rdata;
                if_pc_out   = pc_plus4;
            end
            if_id_wen   = deliver;
            // Any non-stalled cycle without a delivery loads a NOP so IF/ID never repeats.
            if_id_flush = redirect_act || (!stall && !deliver);
        end
    end

    assign imem_addr   = pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc_out;
    logic [31:0] if_inst_out;
    logic        if_id_wen;
    logic        if_id_flush;
    logic [31:0] fetch_count;

    int total;
    int bad;

    fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_pc_out(if_pc_out),
        .if_inst_out(if_inst_out),
        .if_id_wen(if_id_wen),
        .if_id_flush(if_id_flush),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_wen"},   {31'd0, if_id_wen},   32'd0);
        chk({tag, "_flush"}, {31'd0, if_id_flush}, 32'd0);
        chk({tag, "_inst"},  if_inst_out,          32'd0);
        chk({tag, "_pc"},    if_pc_out,            32'd0);
        chk({tag, "_cnt"},   fetch_count,          32'd0);
        chk({tag, "_addr"},  imem_addr,            32'h0040_0000);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;

        #1 rst = 1'b1;
        #1;
        chk_zero_outs("rst");
        step();
        step();
        rst = 1'b0;
        // IDLE: no request; redirect here must be ignored
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1000;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        chk("idle_flush", {31'd0, if_id_flush}, 32'd1);
        step();
        redirect_valid = 1'b0;
        chk("req0_req", {31'd0, imem_req}, 32'd1);
        chk("req0_addr", imem_addr, 32'h0040_0000);

        // first fetch: immediate ready, rvalid next cycle
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h8C01_0004;
        #1;
        chk("f1_wen", {31'd0, if_id_wen}, 32'd1);
        chk("f1_flush", {31'd0, if_id_flush}, 32'd0);
        chk("f1_inst", if_inst_out, 32'h8C01_0004);
        chk("f1_pc", if_pc_out, 32'h0040_0004);
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("f1_cnt", fetch_count, 32'd1);
        chk("f1_next_req", {31'd0, imem_req}, 32'd1);
        chk("f1_next_addr", imem_addr, 32'h0040_0004);

        // stall on rvalid, held 3 cycles
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        stall = 1'b1;
        #1;
        chk("st1_wen", {31'd0, if_id_wen}, 32'd0);
        chk("st1_flush", {31'd0, if_id_flush}, 32'd0);
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("st2_wen", {31'd0, if_id_wen}, 32'd0);
        chk("st2_flush", {31'd0, if_id_flush}, 32'd0);
        step();
        chk("st3_wen", {31'd0, if_id_wen}, 32'd0);
        chk("st3_flush", {31'd0, if_id_flush}, 32'd0);
        chk("st3_cnt", fetch_count, 32'd1);
        step();
        stall = 1'b0;
        #1;
        chk("rel_wen", {31'd0, if_id_wen}, 32'd1);
        chk("rel_flush", {31'd0, if_id_flush}, 32'd0);
        chk("rel_inst", if_inst_out, 32'h1234_5678);
        chk("rel_pc", if_pc_out, 32'h0040_0008);
        step();
        chk("rel_cnt", fetch_count, 32'd2);
        chk("rel_next_addr", imem_addr, 32'h0040_0008);
        chk("rel_next_req", {31'd0, imem_req}, 32'd1);

        // redirect in WAIT, late rvalid dropped
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0103;
        #1;
        chk("rdw_flush", {31'd0, if_id_flush}, 32'd1);
        chk("rdw_wen", {31'd0, if_id_wen}, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rdw_wait_req", {31'd0, imem_req}, 32'd0);
        chk("rdw_wait_flush", {31'd0, if_id_flush}, 32'd1);
        step();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rdw_drop_wen", {31'd0, if_id_wen}, 32'd0);
        chk("rdw_drop_flush", {31'd0, if_id_flush}, 32'd1);
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("rdw_next_req", {31'd0, imem_req}, 32'd1);
        chk("rdw_next_addr", imem_addr, 32'h0040_0100);
        chk("rdw_cnt", fetch_count, 32'd2);

        // redirect + stall + rvalid together
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0200;
        #1;
        chk("rsv_flush", {31'd0, if_id_flush}, 32'd1);
        chk("rsv_wen", {31'd0, if_id_wen}, 32'd0);
        step();
        imem_rvalid = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rsv_cnt", fetch_count, 32'd2);
        chk("rsv_req", {31'd0, imem_req}, 32'd1);
        chk("rsv_addr", imem_addr, 32'h0040_0200);

        // redirect in REQ without ready, then pc+4 wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        #1;
        chk("wrap_flush", {31'd0, if_id_flush}, 32'd1);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0013;
        #1;
        chk("wrap_wen", {31'd0, if_id_wen}, 32'd1);
        chk("wrap_pc", if_pc_out, 32'h0000_0000);
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        chk("wrap_cnt", fetch_count, 32'd3);

        // async reset in the middle of WAIT
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero_outs("mrst");
        step();
        rst = 1'b0;
        #1;
        chk("mrst_idle_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("mrst_req", {31'd0, imem_req}, 32'd1);
        chk("mrst_addr", imem_addr, 32'h0040_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC and issues single-outstanding requests to a variable-latency instruction memory. It delivers each instruction together with its PC+4 into IF/ID, and drives the IF/ID write-enable and flush controls. It also honours decode stalls from the hazard unit and branch/jump redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset; asynchronous, active-high
stall  in  1  hazard unit: hold IF/ID and the current fetch
redirect_valid  in  1  one-cycle pulse: branch/jump taken
redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address; always equal to the PC register
imem_ready  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  32  instruction word
if_pc_out  out  32  PC+4 of the delivered instruction; drives IF/ID pc_in
if_inst_out  out  32  delivered instruction; drives IF/ID inst_in
if_id_wen  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID flush (loads a zero NOP)
fetch_count  out  32  number of instructions delivered; wraps modulo 2^32

Behaviour:
- State register: pc[31:0], state {IDLE, REQ, WAIT, HOLD}, drop flag, inst_buf[31:0], fetch_count.
- Reset, asynchronous:
  - pc=RESET_PC, state=IDLE, drop=0, inst_buf=0, fetch_count=0.
  - Combinational outputs evaluate to imem_req=0, if_id_wen=0, if_id_flush=0, if_inst_out=0, if_pc_out=0.
- IDLE: no request. Go to REQ on the next clock. imem_rvalid is ignored.
- REQ:
  - imem_req=1, imem_addr=pc. Request stays asserted, with a stable address, until imem_ready.
  - If imem_ready: go to WAIT.
- WAIT:
  - Wait for imem_rvalid. rvalid never arrives in the acceptance cycle; the earliest is the next cycle.
  - On rvalid with drop=0 and stall=0: deliver combinationally (if_inst_out=imem_rdata, if_pc_out=pc+4, if_id_wen=1); pc<=pc+4; fetch_count+=1; go to REQ.
  - On rvalid with drop=0 and stall=1: inst_buf<=imem_rdata; go to HOLD.
  - On rvalid with drop=1: discard the response, clear drop, go to REQ; the pc is not incremented.
- HOLD:
  - if_inst_out=inst_buf, if_pc_out=pc+4, if_id_wen=~stall.
  - When stall=0: pc<=pc+4; fetch_count+=1; go to REQ.
- Bubble rule: if_id_flush=1 whenever stall=0 and no delivery occurs this cycle. This prevents IF/ID re-issuing a stale instruction.
- Stall rule: with stall=1 and no redirect, if_id_wen=0 and if_id_flush=0, so IF/ID holds.
- Redirect (highest priority, any state except IDLE):
  - if_id_flush=1 and if_id_wen=0 that cycle; pc<={redirect_pc[31:2],2'b00}.
  - REQ without imem_ready: stay in REQ; the new address takes effect next cycle.
  - REQ with imem_ready the same cycle: the old-address request is in flight; go to WAIT with drop=1.
  - WAIT without rvalid: set drop=1.
  - WAIT with rvalid the same cycle: discard the response; go to REQ.
  - HOLD: discard inst_buf; go to REQ.
  - The same-cycle stall is ignored; fetch_count is not incremented.
- Redirect during IDLE is ignored; the PC remains RESET_PC.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Throughput: one instruction per 2 cycles when ready is immediate and rvalid comes on the next cycle.
- The instruction memory is reset by the same rst, so no response survives a reset.

Test Plan:
- Reset with RESET_PC=0x0040_0000 -> during rst all outputs 0; first cycle after release imem_req=0; next cycle imem_req=1, imem_addr=0x0040_0000.
- imem_ready=1 immediately, rdata=0x8C01_0004 returned the next cycle -> if_id_wen=1, if_inst_out=0x8C01_0004, if_pc_out=0x0040_0004, fetch_count=1; next request at 0x0040_0004.
- stall=1 in the rvalid cycle, held 3 cycles -> wen=0 and flush=0 for 3 cycles; on release wen=1 with the buffered instruction, fetch_count increments once.
- Redirect to 0x0040_0103 while in WAIT; late rvalid 2 cycles after -> flush=1 in the redirect cycle; response discarded (wen=0, flush=1); next imem_addr=0x0040_0100.
- Redirect together with stall=1 and rvalid -> flush=1, wen=0, fetch_count unchanged, next imem_addr equals the redirect target.
- rst asserted mid-WAIT -> outputs return to the reset values immediately (before any clock edge), pc=RESET_PC, fetch_count=0; fetch restarts through IDLE.
